// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: streams one IMG_W x IMG_H frame from a synchronous image
// memory into the sliding-window convolutor and qualifies its result stream.
// A frame runs IDLE -> FETCH (one address per cycle) -> DRAIN (flush the
// convolutor pipeline) -> DONE (one-cycle pulse) -> IDLE.
// Legal windows are tagged with their output-map row/column.
module conv_seq_ctrl #(
    parameter int IMG_W      = 4,
    parameter int IMG_H      = 4,
    parameter int K_SIZE     = 3,
    parameter int STRIDE     = 1,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 14,
    parameter int PIPE_LAT   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    output logic                  mem_en_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    output logic                  conv_en_o,
    output logic [DATA_WIDTH-1:0] conv_data_o,
    input  logic [DATA_WIDTH-1:0] conv_result_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    output logic [15:0]           out_row_o,
    output logic [15:0]           out_col_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int NPIX  = IMG_W * IMG_H;
    localparam int PIX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int DRN_W = (PIPE_LAT > 0) ? $clog2(PIPE_LAT + 1) : 1;
    localparam int TAP_W = 33;

    localparam logic [15:0] KM1      = 16'(K_SIZE - 1);
    localparam logic [15:0] LAST_COL = 16'(IMG_W - 1);
    localparam logic [15:0] LAST_ROW = 16'(IMG_H - 1);
    localparam logic [15:0] LAST_PH  = 16'(STRIDE - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]            state_reg;
    logic [PIX_W-1:0]      pix_reg;
    logic [DRN_W-1:0]      drain_reg;
    logic [ADDR_WIDTH-1:0] base_reg;
    logic                  pix_valid_reg;   // sample on conv_data_o is a real frame pixel
    logic                  start_ok;

    logic [15:0] col_reg, row_reg, col_ph_reg, row_ph_reg, ocol_reg, orow_reg;
    logic [15:0] col_next, row_next, col_ph_next, row_ph_next, ocol_next, orow_next;

    logic              legal;
    logic [TAP_W-1:0]  tap_in;
    logic [TAP_W-1:0]  tap_out;
    logic              tap_legal;

    logic [DATA_WIDTH-1:0] data_hold_reg;
    logic [15:0]           row_hold_reg;
    logic [15:0]           col_hold_reg;

    assign start_ok = (state_reg == S_IDLE) && start_i;

    // Frame sequencer: address counter during FETCH, latency counter during DRAIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            pix_reg   <= '0;
            drain_reg <= '0;
            base_reg  <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start_i) begin
                        state_reg <= S_FETCH;
                        pix_reg   <= '0;
                        base_reg  <= base_addr_i;
                    end
                end
                S_FETCH: begin
                    if (pix_reg == PIX_W'(NPIX - 1)) begin
                        state_reg <= S_DRAIN;
                        drain_reg <= '0;
                    end else begin
                        pix_reg <= pix_reg + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (drain_reg == DRN_W'(PIPE_LAT)) begin
                        state_reg <= S_DONE;
                    end else begin
                        drain_reg <= drain_reg + 1'b1;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    // Memory read data arrives one cycle after its address; mark those cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_valid_reg <= 1'b0;
        end else begin
            pix_valid_reg <= (state_reg == S_FETCH);
        end
    end

    assign mem_en_o    = (state_reg == S_FETCH);
    assign mem_addr_o  = mem_en_o ? (base_reg + ADDR_WIDTH'(pix_reg)) : '0;
    assign busy_o      = (state_reg != S_IDLE);
    assign done_o      = (state_reg == S_DONE);
    assign conv_en_o   = pix_valid_reg || (state_reg == S_DRAIN);
    // The memory's own read register provides the one-cycle copy; gate it so
    // the convolutor sees zeros outside the pixel stream.
    assign conv_data_o = pix_valid_reg ? mem_data_i : '0;

    // Next raster position, stride phases and output coordinates (counters only).
    always_comb begin
        col_next    = col_reg;
        row_next    = row_reg;
        col_ph_next = col_ph_reg;
        row_ph_next = row_ph_reg;
        ocol_next   = ocol_reg;
        orow_next   = orow_reg;

        col_next    = (col_reg == LAST_COL) ? 16'd0 : col_reg + 16'd1;
        col_ph_next = ((col_next == KM1) || (col_ph_reg == LAST_PH)) ? 16'd0 : col_ph_reg + 16'd1;
        ocol_next   = (col_next <= KM1) ? 16'd0 :
                      ((col_ph_next == 16'd0) ? ocol_reg + 16'd1 : ocol_reg);

        if (col_reg == LAST_COL) begin
            row_next    = (row_reg == LAST_ROW) ? 16'd0 : row_reg + 16'd1;
            row_ph_next = ((row_next == KM1) || (row_ph_reg == LAST_PH)) ? 16'd0 : row_ph_reg + 16'd1;
            orow_next   = (row_next <= KM1) ? 16'd0 :
                          ((row_ph_next == 16'd0) ? orow_reg + 16'd1 : orow_reg);
        end
    end

    // Position counters describe the pixel currently on conv_data_o.
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            col_reg    <= '0;
            row_reg    <= '0;
            col_ph_reg <= '0;
            row_ph_reg <= '0;
            ocol_reg   <= '0;
            orow_reg   <= '0;
        end else if (pix_valid_reg) begin
            col_reg    <= col_next;
            row_reg    <= row_next;
            col_ph_reg <= col_ph_next;
            row_ph_reg <= row_ph_next;
            ocol_reg   <= ocol_next;
            orow_reg   <= orow_next;
        end
    end

    assign legal  = pix_valid_reg && (row_reg >= KM1) && (col_reg >= KM1) &&
                    (col_ph_reg == 16'd0) && (row_ph_reg == 16'd0);
    assign tap_in = {legal, orow_reg, ocol_reg};

    // Delay the legal flag and coordinates to line up with the convolutor output.
    generate
        if (PIPE_LAT == 0) begin : g_nodly
            assign tap_out = tap_in;
        end else begin : g_dly
            for (genvar gi = 0; gi < PIPE_LAT; gi++) begin : g_stage
                logic [TAP_W-1:0] stage_reg;
                logic [TAP_W-1:0] prev;
                if (gi == 0) begin : g_first
                    assign prev = tap_in;
                end else begin : g_chain
                    assign prev = g_stage[gi-1].stage_reg;
                end
                // One pipeline stage of the qualifier delay line.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        stage_reg <= '0;
                    end else begin
                        stage_reg <= prev;
                    end
                end
            end
            assign tap_out = g_stage[PIPE_LAT-1].stage_reg;
        end
    endgenerate

    assign tap_legal = tap_out[TAP_W-1];

    // Remember the last qualified result so outputs hold between results.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_hold_reg <= '0;
            row_hold_reg  <= '0;
            col_hold_reg  <= '0;
        end else if (tap_legal) begin
            data_hold_reg <= conv_result_i;
            row_hold_reg  <= tap_out[31:16];
            col_hold_reg  <= tap_out[15:0];
        end
    end

    assign valid_o   = tap_legal;
    assign data_o    = tap_legal ? conv_result_i  : data_hold_reg;
    assign out_row_o = tap_legal ? tap_out[31:16] : row_hold_reg;
    assign out_col_o = tap_legal ? tap_out[15:0]  : col_hold_reg;

endmodule
